// File: rtl/quan_instr_fetcher_if.sv
// Instruction stream and conv-engine handshake bundle for the instruction fetcher.
// The fetcher takes the slave side; the stream source and conv engine take master.
interface quan_instr_fetcher_if #(
    parameter int word_w  = 32,
    parameter int instr_w = 512
) ();
    logic [word_w-1:0]  instr_word;
    logic               instr_valid;
    logic               instr_ready;
    logic               conv_done;
    logic               conv_decode;
    logic [instr_w-1:0] conv_instr_args;

    modport master (
        output instr_word,
        output instr_valid,
        output conv_done,
        input  instr_ready,
        input  conv_decode,
        input  conv_instr_args
    );

    modport slave (
        input  instr_word,
        input  instr_valid,
        input  conv_done,
        output instr_ready,
        output conv_decode,
        output conv_instr_args
    );
endinterface

// File: rtl/quan_instr_fetcher.sv
// Packs 32-bit stream words into 512-bit conv instructions and issues one per layer,
// prefetching the next instruction while the conv engine works on the current one.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no run active; waits for start
// FETCH     | filling the staging buffer; leaves once all words are staged
// ISSUE     | conv_decode high, conv_instr_args holds the new instruction
// WAIT_DONE | layer running; prefetches next instruction; waits for conv_done
// FIN       | all_done high for one cycle, then back to IDLE
module quan_instr_fetcher #(
    parameter int word_w          = 32,
    parameter int instr_w         = 512,
    parameter int words_per_instr = 16,
    parameter int cnt_w           = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          layer_num,
    quan_instr_fetcher_if.slave  bus,
    output logic                 busy,
    output logic                 all_done
);
    localparam int idx_w = $clog2(words_per_instr);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(words_per_instr);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        FIN
    } state_t;

    state_t             state;
    logic [instr_w-1:0] staging;
    logic [instr_w-1:0] staging_nxt;
    logic [cnt_w-1:0]   word_cnt;
    logic [cnt_w-1:0]   word_cnt_nxt;
    logic [idx_w-1:0]   word_idx;
    logic [15:0]        layers_left;
    logic               transfer;
    logic               full_nxt;

    // Ready depends only on registered state so there is no valid->ready path.
    assign bus.instr_ready = ((state == FETCH) ||
                              ((state == WAIT_DONE) && (layers_left != 16'd0))) &&
                             (word_cnt < full_cnt);
    assign transfer = bus.instr_valid && bus.instr_ready;
    assign word_idx = word_cnt[idx_w-1:0];

    always_comb begin
        staging_nxt  = staging;
        word_cnt_nxt = word_cnt;
        if (transfer) begin
            staging_nxt[word_idx*word_w +: word_w] = bus.instr_word;
            word_cnt_nxt = word_cnt + 1'b1;
        end
    end

    // A conv_done landing on the same edge as the last word sees the buffer full.
    assign full_nxt = (word_cnt_nxt == full_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            staging             <= '0;
            word_cnt            <= '0;
            layers_left         <= '0;
            busy                <= 1'b0;
            all_done            <= 1'b0;
            bus.conv_decode     <= 1'b0;
            bus.conv_instr_args <= '0;
        end else begin
            bus.conv_decode <= 1'b0;
            all_done        <= 1'b0;
            staging         <= staging_nxt;
            word_cnt        <= word_cnt_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (layer_num == 16'd0) begin
                            all_done <= 1'b1;
                        end else begin
                            layers_left <= layer_num;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (word_cnt == full_cnt) begin
                        bus.conv_decode     <= 1'b1;
                        bus.conv_instr_args <= staging;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    word_cnt    <= '0;
                    layers_left <= layers_left - 16'd1;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.conv_done) begin
                        if (layers_left == 16'd0) begin
                            all_done <= 1'b1;
                            state    <= FIN;
                        end else if (full_nxt) begin
                            bus.conv_decode     <= 1'b1;
                            bus.conv_instr_args <= staging_nxt;
                            state               <= ISSUE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quan_instr_fetcher.sv
// Randomized bench for quan_instr_fetcher against a transfer/event-level reference model.
module tb_quan_instr_fetcher;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] layer_num;
    logic        busy;
    logic        all_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [511:0] g_last_args = '0;

    quan_instr_fetcher_if bus ();

    quan_instr_fetcher dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .layer_num (layer_num),
        .bus       (bus),
        .busy      (busy),
        .all_done  (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_all_done"}, all_done, 0);
        check({tag, "_decode"}, bus.conv_decode, 0);
        check({tag, "_ready"}, bus.instr_ready, 0);
        check({tag, "_args"}, bus.conv_instr_args, 0);
    endtask

    // Model: instruction k is words 16k..16k+15, word 0 in the LSBs. Edge numbers are
    // the cyc value seen at the following negedge. Instruction 0 issues one edge after
    // its 16th word; later ones issue on the conv_done edge if already staged, else one
    // edge after their 16th word.
    task automatic run_net(input int L, input int vmode, input int dmin, input int dmax,
                           input int abort_at);
        logic [31:0]  wq[$];
        int           t_full[$];
        int           t_done[$];
        int           n_xfer = 0, n_dec = 0, n_done = 0;
        int           s_edge, t_fin = -1, done_at = -1, iter = 0, e_edge, tw, td;
        bit           tog = 0, finished = 0, abort_pend = 0, known, exp_dec, exp_busy, exp_ad;
        bit           bad_ready, v;
        logic [511:0] e;

        for (int i = 0; i < 16 * L; i++) wq.push_back($urandom);
        @(negedge clk);
        s_edge    = cyc + 1;
        start     = 1'b1;
        layer_num = L[15:0];
        bus.conv_done   = 1'b0;
        bus.instr_valid = 1'b0;

        while (!finished && iter < 4000) begin
            @(negedge clk);
            iter++;
            start         = 1'b0;
            bus.conv_done = 1'b0;

            if (abort_pend) begin
                reset = 1'b1;
                bus.instr_valid = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                reset = 1'b0;
                g_last_args = '0;
                finished = 1;
                break;
            end

            known = 0;
            e_edge = -1;
            if (n_dec < L && t_full.size() > n_dec) begin
                if (n_dec == 0) begin
                    e_edge = t_full[0] + 1;
                    known = 1;
                end else if (t_done.size() >= n_dec) begin
                    tw = t_full[n_dec];
                    td = t_done[n_dec-1];
                    e_edge = (tw <= td) ? td : tw + 1;
                    known = 1;
                end
            end
            exp_dec = known && (cyc == e_edge);
            check("decode", bus.conv_decode, exp_dec);
            if (exp_dec) begin
                for (int i = 0; i < 16; i++) e[32*i +: 32] = wq[16*n_dec + i];
                check("args", bus.conv_instr_args, e);
                g_last_args = e;
                n_dec++;
                done_at = cyc + 1 + $urandom_range(dmax, dmin);
                if (n_dec == 1) begin
                    start     = 1'b1;
                    layer_num = 16'hffff;
                end
            end else begin
                check("args_hold", bus.conv_instr_args, g_last_args);
            end

            if (L == 0) begin
                exp_busy = 0;
                exp_ad   = (cyc == s_edge);
            end else begin
                exp_busy = (cyc >= s_edge) && !(t_fin >= 0 && cyc > t_fin);
                exp_ad   = (t_fin >= 0) && (cyc == t_fin);
            end
            check("busy", busy, exp_busy);
            check("all_done", all_done, exp_ad);

            bad_ready = (n_xfer >= 16 * L) || (n_xfer - 16 * n_dec >= 16) || !exp_busy;
            if (bad_ready) check("no_ready", bus.instr_ready, 0);

            if ((L == 0 && cyc == s_edge + 1) || (t_fin >= 0 && cyc == t_fin + 1)) begin
                finished = 1;
                break;
            end

            if (L > 0 && cyc == s_edge) bus.conv_done = 1'b1;
            if (done_at == cyc + 1) begin
                bus.conv_done = 1'b1;
                t_done.push_back(cyc + 1);
                n_done++;
                if (n_done == L) t_fin = cyc + 1;
                done_at = -1;
            end

            v = 0;
            if (n_xfer < 16 * L) begin
                case (vmode)
                    0: v = 1;
                    1: begin tog = ~tog; v = tog; end
                    2: v = ($urandom_range(3, 0) != 0);
                    default: v = $urandom_range(1, 0) != 0;
                endcase
            end
            bus.instr_valid = v;
            bus.instr_word  = v ? wq[n_xfer] : $urandom;
            if (v && bus.instr_ready) begin
                n_xfer++;
                if (n_xfer % 16 == 0) t_full.push_back(cyc + 1);
                if (abort_at >= 0 && n_xfer == abort_at) abort_pend = 1;
            end
        end

        bus.instr_valid = 1'b0;
        bus.conv_done   = 1'b0;
        start           = 1'b0;
        check("run_complete", finished, 1);
        if (abort_at < 0) begin
            check("n_decode", n_dec, L);
            check("n_xfer", n_xfer, 16 * L);
        end
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        layer_num       = '0;
        bus.instr_valid = 1'b0;
        bus.instr_word  = '0;
        bus.conv_done   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        run_net(1, 0, 3, 3, -1);
        run_net(1, 1, 2, 5, -1);
        run_net(3, 2, 30, 40, -1);
        run_net(3, 3, 1, 3, -1);
        run_net(0, 0, 1, 1, -1);
        run_net(3, 0, 5, 5, 7);
        run_net(2, 2, 1, 10, -1);
        for (int r = 0; r < 6; r++)
            run_net($urandom_range(5, 1), $urandom_range(3, 0), 1, $urandom_range(25, 1), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
